// File: rtl/sbit_monitor.sv
// Per-VFAT S-bit monitor: armed one-shot capture of the first hit word with hit-to-L1A BX delay,
// plus saturating hit-BX and alignment-loss counters.
module sbit_monitor #(
    parameter int unsigned MXSBITS  = 64,
    parameter int unsigned CNT_BITS = 32,
    parameter int unsigned DLY_BITS = 12
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [MXSBITS-1:0]  sbits,
    input  logic                sof_is_aligned,
    input  logic                arm,
    input  logic                clear,
    input  logic                l1a,
    output logic                armed,
    output logic                valid,
    output logic [MXSBITS-1:0]  snap_sbits,
    output logic [DLY_BITS-1:0] snap_delay,
    output logic                snap_l1a_seen,
    output logic [CNT_BITS-1:0] hit_bx_count,
    output logic [15:0]         align_loss_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        WAIT_L1A = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [DLY_BITS-1:0] DMAX    = '1;
    localparam logic [DLY_BITS-1:0] DLY_ONE = DLY_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_t              state;
    logic [DLY_BITS-1:0] delay;
    logic                aligned_q;
    logic                hit;
    logic                align_fall;

    assign hit        = sof_is_aligned & (|sbits);
    assign align_fall = aligned_q & ~sof_is_aligned;

    // delay holds (edges since hit) - 1, so timeout fires at hit edge + DMAX with delay == DMAX-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            armed         <= 1'b0;
            valid         <= 1'b0;
            delay         <= '0;
            snap_sbits    <= '0;
            snap_delay    <= '0;
            snap_l1a_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                end
                ARMED: begin
                    if (hit) begin
                        snap_sbits <= sbits;
                        snap_delay <= '0;
                        delay      <= '0;
                        if (l1a) begin
                            snap_l1a_seen <= 1'b1;
                            state         <= DONE;
                            armed         <= 1'b0;
                            valid         <= 1'b1;
                        end else begin
                            snap_l1a_seen <= 1'b0;
                            state         <= WAIT_L1A;
                        end
                    end
                end
                WAIT_L1A: begin
                    if (l1a) begin
                        snap_l1a_seen <= 1'b1;
                        snap_delay    <= delay + DLY_ONE;
                        state         <= DONE;
                        armed         <= 1'b0;
                        valid         <= 1'b1;
                    end else if (delay == DMAX - DLY_ONE) begin
                        snap_l1a_seen <= 1'b0;
                        snap_delay    <= DMAX;
                        state         <= DONE;
                        armed         <= 1'b0;
                        valid         <= 1'b1;
                    end else begin
                        delay <= delay + DLY_ONE;
                    end
                end
                DONE: begin
                    if (arm) begin
                        state <= ARMED;
                        armed <= 1'b1;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    armed <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            aligned_q        <= 1'b0;
            hit_bx_count     <= '0;
            align_loss_count <= '0;
        end else begin
            aligned_q <= sof_is_aligned;
            if (clear) begin
                hit_bx_count     <= '0;
                align_loss_count <= '0;
            end else begin
                if (hit && (hit_bx_count != '1))
                    hit_bx_count <= hit_bx_count + CNT_ONE;
                if (align_fall && (align_loss_count != '1))
                    align_loss_count <= align_loss_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sbit_monitor.sv
// Directed bench for sbit_monitor: capture, coincident L1A, timeout, gating, counters, async reset.
module tb_sbit_monitor;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [63:0] sbits;
    logic        sof_is_aligned;
    logic        arm;
    logic        clear;
    logic        l1a;

    logic        armed, valid, snap_l1a_seen;
    logic [63:0] snap_sbits;
    logic [11:0] snap_delay;
    logic [31:0] hit_bx_count;
    logic [15:0] align_loss_count;

    logic        armed4, valid4, snap_l1a_seen4;
    logic [63:0] snap_sbits4;
    logic [11:0] snap_delay4;
    logic [3:0]  hit_bx_count4;
    logic [15:0] align_loss_count4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    sbit_monitor #(.MXSBITS(64), .CNT_BITS(32), .DLY_BITS(12)) dut (
        .clock(clock), .reset_n(reset_n), .sbits(sbits), .sof_is_aligned(sof_is_aligned),
        .arm(arm), .clear(clear), .l1a(l1a),
        .armed(armed), .valid(valid), .snap_sbits(snap_sbits), .snap_delay(snap_delay),
        .snap_l1a_seen(snap_l1a_seen), .hit_bx_count(hit_bx_count),
        .align_loss_count(align_loss_count)
    );

    sbit_monitor #(.MXSBITS(64), .CNT_BITS(4), .DLY_BITS(12)) dut4 (
        .clock(clock), .reset_n(reset_n), .sbits(sbits), .sof_is_aligned(sof_is_aligned),
        .arm(arm), .clear(clear), .l1a(l1a),
        .armed(armed4), .valid(valid4), .snap_sbits(snap_sbits4), .snap_delay(snap_delay4),
        .snap_l1a_seen(snap_l1a_seen4), .hit_bx_count(hit_bx_count4),
        .align_loss_count(align_loss_count4)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_armed"},  64'(armed), 64'd0);
        check({tag, "_valid"},  64'(valid), 64'd0);
        check({tag, "_snap"},   snap_sbits, 64'd0);
        check({tag, "_delay"},  64'(snap_delay), 64'd0);
        check({tag, "_seen"},   64'(snap_l1a_seen), 64'd0);
        check({tag, "_hits"},   64'(hit_bx_count), 64'd0);
        check({tag, "_aloss"},  64'(align_loss_count), 64'd0);
        check({tag, "_hits4"},  64'(hit_bx_count4), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; sbits = '0; sof_is_aligned = 1'b0;
        arm = 1'b0; clear = 1'b0; l1a = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        sof_is_aligned = 1'b1;
        tick();
        check("no_false_aloss", 64'(align_loss_count), 64'd0);

        // Capture with L1A: arm edge 0, hit edge 5, l1a edge 8
        arm = 1'b1; tick(); arm = 1'b0;
        check("t1_armed", 64'(armed), 64'd1);
        repeat (4) tick();
        sbits = 64'h100; tick(); sbits = '0;
        check("t1_snap", snap_sbits, 64'h100);
        check("t1_armed_wait", 64'(armed), 64'd1);
        check("t1_valid_wait", 64'(valid), 64'd0);
        tick(); tick();
        l1a = 1'b1; tick(); l1a = 1'b0;
        check("t1_valid", 64'(valid), 64'd1);
        check("t1_armed_done", 64'(armed), 64'd0);
        check("t1_delay", 64'(snap_delay), 64'd3);
        check("t1_seen", 64'(snap_l1a_seen), 64'd1);
        check("t1_hits", 64'(hit_bx_count), 64'd1);

        // Coincident hit and L1A
        arm = 1'b1; tick(); arm = 1'b0;
        check("t2_valid_drop", 64'(valid), 64'd0);
        sbits = 64'hABCD; l1a = 1'b1; tick(); sbits = '0; l1a = 1'b0;
        check("t2_valid", 64'(valid), 64'd1);
        check("t2_delay", 64'(snap_delay), 64'd0);
        check("t2_seen", 64'(snap_l1a_seen), 64'd1);
        check("t2_snap", snap_sbits, 64'hABCD);

        // Timeout: hit at edge N, DONE after edge N+4095
        arm = 1'b1; tick(); arm = 1'b0;
        sbits = 64'h5; tick(); sbits = '0;
        repeat (4094) tick();
        check("t3_not_yet", 64'(valid), 64'd0);
        check("t3_still_armed", 64'(armed), 64'd1);
        tick();
        check("t3_valid", 64'(valid), 64'd1);
        check("t3_delay", 64'(snap_delay), 64'd4095);
        check("t3_seen", 64'(snap_l1a_seen), 64'd0);
        arm = 1'b1; tick(); arm = 1'b0;
        check("t3_rearm_valid", 64'(valid), 64'd0);
        check("t3_rearm_armed", 64'(armed), 64'd1);
        check("t3_keep_snap", snap_sbits, 64'h5);
        check("t3_keep_delay", 64'(snap_delay), 64'd4095);
        check("t3_hits", 64'(hit_bx_count), 64'd3);

        // Alignment gating while ARMED
        sof_is_aligned = 1'b0; sbits = '1;
        repeat (10) tick();
        check("t4_no_capture", snap_sbits, 64'h5);
        check("t4_armed", 64'(armed), 64'd1);
        check("t4_hits", 64'(hit_bx_count), 64'd3);
        check("t4_aloss1", 64'(align_loss_count), 64'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        check("t4_clr_aloss", 64'(align_loss_count), 64'd0);
        check("t4_clr_hits", 64'(hit_bx_count), 64'd0);
        check("t4_clr_keeps_fsm", 64'(armed), 64'd1);
        sbits = '0;
        for (int i = 0; i < 3; i++) begin
            sof_is_aligned = 1'b1; tick();
            sof_is_aligned = 1'b0; tick();
        end
        check("t4_aloss3", 64'(align_loss_count), 64'd3);

        // Counter saturation (CNT_BITS=4 instance) and clear beating an increment
        sof_is_aligned = 1'b1; sbits = 64'h1;
        repeat (20) tick();
        check("t5_sat4", 64'(hit_bx_count4), 64'd15);
        check("t5_hits32", 64'(hit_bx_count), 64'd20);
        clear = 1'b1; tick(); clear = 1'b0;
        check("t5_clr4", 64'(hit_bx_count4), 64'd0);
        check("t5_clr32", 64'(hit_bx_count), 64'd0);
        check("t5_clr_aloss", 64'(align_loss_count), 64'd0);
        check("t5_snap_kept", snap_sbits, 64'h1);
        check("t5_wait_armed", 64'(armed), 64'd1);
        sbits = '0;

        // Asynchronous reset while in WAIT_L1A
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        tick();
        reset_n = 1'b1;
        sbits = 64'h77; tick(); sbits = '0;
        check("t6_idle_no_capture", snap_sbits, 64'd0);
        check("t6_idle_armed", 64'(armed), 64'd0);
        check("t6_idle_valid", 64'(valid), 64'd0);
        arm = 1'b1; tick(); arm = 1'b0;
        check("t6_rearm", 64'(armed), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
